// File: rtl/servant_uart_rx_if.sv
// -----------------------------------------------------------------------------
// servant_uart_rx_if
// Byte stream handshake between the UART receiver FIFO and its consumer.
//   o_rdt  : received byte at the FIFO head (receiver -> consumer)
//   o_vld  : head byte valid, FIFO non-empty (receiver -> consumer)
//   i_rdy  : consumer accepts o_rdt when o_vld && i_rdy (consumer -> receiver)
// Modports: master = receiver side, slave = consumer side.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface servant_uart_rx_if;
  logic [7:0] o_rdt;
  logic       o_vld;
  logic       i_rdy;

  modport master (output o_rdt, output o_vld, input i_rdy);
  modport slave  (input o_rdt, input o_vld, output i_rdy);
endinterface

// File: rtl/servant_uart_rx.sv
// -----------------------------------------------------------------------------
// servant_uart_rx
// UART receiver for the servant o_data line: 2-flop synchronizer, frame FSM
// (start / 8 data bits LSB first / optional even parity / stop) and a small
// receive FIFO with a valid/ready read side.
//
// Configuration macro: SERVANT_UART_RX_PARITY_EN
//   defined   : frame is 8E1; a PARITY state checks one even-parity bit.
//   undefined : frame is 8N1; o_par_err is tied low.
//
// Parameters:
//   CLKS_PER_BIT : wb_clk cycles per UART bit (4..65535)
//   FIFO_AW      : log2 of receive FIFO depth
// Ports:
//   wb_clk      : clock, all state changes on its rising edge
//   wb_rst      : asynchronous active-high reset
//   i_rx        : serial input, idles high
//   bus         : master side of servant_uart_rx_if (o_rdt, o_vld, i_rdy)
//   o_frame_err : one-cycle pulse on a bad stop bit
//   o_ovf       : one-cycle pulse when a good byte is dropped (FIFO full)
//   o_par_err   : one-cycle pulse on parity mismatch (always 0 without parity)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module servant_uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 2
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic                  i_rx,
  servant_uart_rx_if.master     bus,
  output logic                  o_frame_err,
  output logic                  o_ovf,
  output logic                  o_par_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  // Reload values for the down-counter: a sample happens when it reaches 0.
  // The first reload lands the start-bit sample CLKS_PER_BIT/2-1 cycles after
  // detection; every later reload gives exactly CLKS_PER_BIT cycles.
  localparam logic [15:0] L_HALF = 16'(CLKS_PER_BIT / 2 - 2);
  localparam logic [15:0] L_FULL = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef SERVANT_UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  // Even parity: the parity bit must make the total count of ones even.
  function automatic logic f_even_par(input logic [7:0] d);
    return ^d;
  endfunction

  logic             r_s1, r_s2;
  state_t           r_state;
  logic [15:0]      r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_frame_err;
  logic             r_ovf;
  logic [FIFO_AW:0] r_wptr, r_rptr;
  logic [7:0]       r_mem [DEPTH];
`ifdef SERVANT_UART_RX_PARITY_EN
  logic             r_par_bad;
  logic             r_par_err;
`endif

  logic w_tick, w_push, w_pop, w_empty, w_full, w_wr;

  assign w_tick = (r_cnt == 16'd0);

  // A byte is offered to the FIFO in the stop-sample cycle when the stop bit
  // is good (and parity, if present, matched).
`ifdef SERVANT_UART_RX_PARITY_EN
  assign w_push = (r_state == STOP) && w_tick && r_s2 && !r_par_bad;
`else
  assign w_push = (r_state == STOP) && w_tick && r_s2;
`endif

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                   (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
  assign w_pop   = bus.o_vld && bus.i_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_wr    = w_push && (!w_full || w_pop);

  // Synchronizer + frame FSM
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_s1        <= 1'b1;
      r_s2        <= 1'b1;
      r_state     <= IDLE;
      r_cnt       <= 16'd0;
      r_bit       <= 3'd0;
      r_frame_err <= 1'b0;
`ifdef SERVANT_UART_RX_PARITY_EN
      r_par_bad   <= 1'b0;
      r_par_err   <= 1'b0;
`endif
    end else begin
      r_s1        <= i_rx;
      r_s2        <= r_s1;
      r_frame_err <= 1'b0;
`ifdef SERVANT_UART_RX_PARITY_EN
      r_par_err   <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (!r_s2) begin
            r_state <= START;
            r_cnt   <= L_HALF;
            r_bit   <= 3'd0;
          end
        end
        START: begin
          if (w_tick) begin
            // Line back high at mid start bit: a glitch, silently ignored.
            if (r_s2) begin
              r_state <= IDLE;
            end else begin
              r_state <= DATA;
              r_cnt   <= L_FULL;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_cnt <= L_FULL;
            r_bit <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
`ifdef SERVANT_UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
`ifdef SERVANT_UART_RX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_cnt     <= L_FULL;
            r_par_bad <= (r_s2 != f_even_par(r_shift));
            r_state   <= STOP;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
`ifdef SERVANT_UART_RX_PARITY_EN
            r_par_err <= r_par_bad;
`endif
            if (r_s2) begin
              r_state <= IDLE;
            end else begin
              // Break or framing error: report once, then wait out the low line.
              r_frame_err <= 1'b1;
              r_state     <= WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        WAIT_HIGH: begin
          if (r_s2) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Data shift register, LSB arrives first
  always_ff @(posedge wb_clk) begin
    if ((r_state == DATA) && w_tick) r_shift <= {r_s2, r_shift[7:1]};
  end

  // FIFO pointers and overflow pulse
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_ovf <= w_push && w_full && !w_pop;
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge wb_clk) begin
    if (w_wr) r_mem[r_wptr[FIFO_AW-1:0]] <= r_shift;
  end

  assign bus.o_rdt   = r_mem[r_rptr[FIFO_AW-1:0]];
  assign bus.o_vld   = !w_empty;
  assign o_frame_err = r_frame_err;
  assign o_ovf       = r_ovf;
`ifdef SERVANT_UART_RX_PARITY_EN
  assign o_par_err   = r_par_err;
`else
  assign o_par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_servant_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_servant_uart_rx
// Directed frames into servant_uart_rx. A frame-level model predicts, for each
// transmitted frame, which edge produces a push / frame error / parity error
// and keeps the expected FIFO contents; a per-cycle compare checks the DUT
// against it. Literal expectations pin latency, ordering and pulse counts.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_servant_uart_rx;
  localparam int CPB   = 16;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
`ifdef SERVANT_UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic wb_clk = 1'b0;
  logic wb_rst = 1'b1;
  logic i_rx   = 1'b1;
  logic o_frame_err, o_ovf, o_par_err;

  servant_uart_rx_if bus();

  servant_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .wb_clk      (wb_clk),
    .wb_rst      (wb_rst),
    .i_rx        (i_rx),
    .bus         (bus),
    .o_frame_err (o_frame_err),
    .o_ovf       (o_ovf),
    .o_par_err   (o_par_err)
  );

  always #5 wb_clk = ~wb_clk;

  // Event kinds: 1 push byte, 2 frame error, 3 parity error, 4 both errors
  typedef struct { int cyc; int kind; logic [7:0] data; } ev_t;
  ev_t        evq[$];
  logic [7:0] mq[$];
  logic [7:0] drained[$];
  int  cyc = 0;
  bit  exp_ferr, exp_ovf, exp_perr;
  int  tests = 0, fails = 0;
  int  ovf_seen = 0, ferr_seen = 0, perr_seen = 0, vld_cycles = 0;
  int  last_start = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance n clock edges, leaving time just after the last edge.
  task automatic hold(input int n);
    repeat (n) @(posedge wb_clk);
    #1;
  endtask

  // Frame model: edge numbers follow from the line timing, the FIFO is a queue.
  initial begin
    ev_t ev;
    bit  pop, full;
    forever begin
      @(posedge wb_clk);
      cyc++;
      exp_ferr = 0; exp_ovf = 0; exp_perr = 0;
      if (wb_rst) begin
        mq.delete();
        evq.delete();
      end else begin
        pop  = (mq.size() > 0) && bus.i_rdy;
        full = (mq.size() == DEPTH);
        if (pop) void'(mq.pop_front());
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
          ev = evq.pop_front();
          case (ev.kind)
            1: if (!full || pop) mq.push_back(ev.data); else exp_ovf = 1;
            2: exp_ferr = 1;
            3: exp_perr = 1;
            default: begin exp_ferr = 1; exp_perr = 1; end
          endcase
        end
      end
    end
  end

  // Per-cycle compare, away from the active edge
  initial begin
    forever begin
      @(negedge wb_clk);
      if (wb_rst) begin
        chk("rst_vld", {31'd0, bus.o_vld}, 0);
        chk("rst_ferr", {31'd0, o_frame_err}, 0);
        chk("rst_ovf", {31'd0, o_ovf}, 0);
        chk("rst_perr", {31'd0, o_par_err}, 0);
      end else begin
        chk("vld", {31'd0, bus.o_vld}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) chk("rdt", {24'd0, bus.o_rdt}, {24'd0, mq[0]});
        chk("frame_err", {31'd0, o_frame_err}, {31'd0, exp_ferr});
        chk("ovf", {31'd0, o_ovf}, {31'd0, exp_ovf});
        chk("par_err", {31'd0, o_par_err}, {31'd0, exp_perr});
      end
      if (bus.o_vld && bus.i_rdy) drained.push_back(bus.o_rdt);
      if (o_ovf) ovf_seen++;
      if (o_frame_err) ferr_seen++;
      if (o_par_err) perr_seen++;
      if (bus.o_vld) vld_cycles++;
    end
  end

  // Sends one frame starting just after an edge; stop_len is in bit times.
  task automatic send_frame(input logic [7:0] d, input logic stopb, input logic parb, input int stop_len);
    ev_t ev;
    bit  par_ok;
    last_start = cyc;
    par_ok = (PAR == 0) || (parb == ^d);
    ev.cyc  = cyc + 2 + CPB / 2 + (9 + PAR) * CPB;
    ev.data = d;
    if (stopb && par_ok)  ev.kind = 1;
    else if (stopb)       ev.kind = 3;
    else if (par_ok)      ev.kind = 2;
    else                  ev.kind = 4;
    evq.push_back(ev);
    i_rx = 1'b0;
    hold(CPB);
    for (int j = 0; j < 8; j++) begin
      i_rx = d[j];
      hold(CPB);
    end
    if (PAR != 0) begin
      i_rx = parb;
      hold(CPB);
    end
    i_rx = stopb;
    hold(CPB * stop_len);
    i_rx = 1'b1;
    hold(CPB);
  endtask

  initial begin
    int         t;
    logic [7:0] r;
    logic [7:0] d7e;
    bus.i_rdy = 1'b1;
    wb_rst    = 1'b1;
    hold(3);
    chk("reset_vld", {31'd0, bus.o_vld}, 0);
    chk("reset_ferr", {31'd0, o_frame_err}, 0);
    wb_rst = 1'b0;
    hold(5);

    // Single 0x55 frame: latency and one-cycle valid
    vld_cycles = 0;
    t = -1;
    r = 8'h00;
    fork
      send_frame(8'h55, 1'b1, ^8'h55, 1);
      begin
        for (int k = 0; k < 400; k++) begin
          @(posedge wb_clk);
          #2;
          if (bus.o_vld) begin
            t = cyc;
            r = bus.o_rdt;
            break;
          end
        end
      end
    join
    chk("lat_55", t - last_start, (PAR != 0) ? 170 : 154);
    chk("rdt_55", {24'd0, r}, 32'h55);
    hold(4);
    chk("vld_cycles_55", vld_cycles, 1);

    // Fill the FIFO with the consumer stalled, then drain
    bus.i_rdy = 1'b0;
    ovf_seen  = 0;
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, ^(8'(b)), 1);
    chk("ovf_once", ovf_seen, 1);
    drained.delete();
    bus.i_rdy = 1'b1;
    hold(8);
    chk("drain_cnt", drained.size(), 4);
    for (int i = 0; i < 4 && i < drained.size(); i++)
      chk("drain_order", {24'd0, drained[i]}, i + 1);

    // 4-cycle glitch is rejected without any report
    ferr_seen = 0; vld_cycles = 0; perr_seen = 0;
    i_rx = 1'b0;
    hold(4);
    i_rx = 1'b1;
    hold(3 * CPB);
    chk("glitch_vld", vld_cycles, 0);
    chk("glitch_ferr", ferr_seen + perr_seen, 0);

    // Break: bad stop bit, line low for 40 bit times, then a good frame
    ferr_seen = 0;
    drained.delete();
    send_frame(8'hA3, 1'b0, ^8'hA3, 40);
    chk("break_ferr", ferr_seen, 1);
    chk("break_nopush", drained.size(), 0);
    send_frame(8'h3C, 1'b1, ^8'h3C, 1);
    hold(2);
    chk("after_break_cnt", drained.size(), 1);
    if (drained.size() > 0) chk("after_break_rdt", {24'd0, drained[0]}, 32'h3C);

    // Reset during bit 3 with a byte still held in the FIFO
    bus.i_rdy = 1'b0;
    send_frame(8'h11, 1'b1, ^8'h11, 1);
    chk("pre_rst_vld", {31'd0, bus.o_vld}, 1);
    d7e = 8'h7E;
    i_rx = 1'b0;
    hold(CPB);
    for (int j = 0; j < 3; j++) begin
      i_rx = d7e[j];
      hold(CPB);
    end
    i_rx = d7e[3];
    hold(CPB / 2);
    wb_rst = 1'b1;
    i_rx   = 1'b1;
    #1;
    chk("async_rst_vld", {31'd0, bus.o_vld}, 0);
    chk("async_rst_errs", {29'd0, o_frame_err, o_ovf, o_par_err}, 0);
    hold(3);
    wb_rst = 1'b0;
    hold(CPB);
    chk("post_rst_vld", {31'd0, bus.o_vld}, 0);
    bus.i_rdy = 1'b1;
    drained.delete();
    send_frame(8'h7E, 1'b1, ^8'h7E, 1);
    hold(2);
    chk("post_rst_cnt", drained.size(), 1);
    if (drained.size() > 0) chk("post_rst_rdt", {24'd0, drained[0]}, 32'h7E);

`ifdef SERVANT_UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the correct parity bit is 1
    perr_seen = 0;
    drained.delete();
    send_frame(8'h07, 1'b1, 1'b0, 1);
    chk("par_bad_pulse", perr_seen, 1);
    chk("par_bad_nopush", drained.size(), 0);
    send_frame(8'h07, 1'b1, 1'b1, 1);
    hold(2);
    chk("par_good_cnt", drained.size(), 1);
    if (drained.size() > 0) chk("par_good_rdt", {24'd0, drained[0]}, 32'h07);
`endif

    hold(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/servant_uart_rx.md
SERVANT_UART_RX -- requirements
Module: servant_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: wb_clk cycles per UART bit (legal range 4..65535).
REQ-002 SHALL have parameter FIFO_AW, default 2: log2 of receive FIFO depth (depth 4 by default).
REQ-003 SHALL have port wb_clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-004 SHALL have port wb_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_rx  input  1  serial line driven by the servant o_data output; idles high.
REQ-006 SHALL have port o_rdt  output  8  received byte at the FIFO head.
REQ-007 SHALL have port o_vld  output  1  high while the FIFO is non-empty.
REQ-008 SHALL have port i_rdy  input  1  consumer accepts o_rdt when o_vld and i_rdy are both high.
REQ-009 SHALL have port o_frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-010 SHALL have port o_ovf  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-011 SHALL have port o_par_err  output  1  one-cycle pulse on parity mismatch (REQ-027); the port SHALL exist in both builds.

Function
REQ-012 SHALL pass i_rx through a 2-flop synchronizer (s1, s2) before any use.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-014 IDLE->START in the cycle s2 reads 0; bit counter cleared; this is detection cycle D.
REQ-015 START: s2 sampled at D+CLKS_PER_BIT/2-1; sample 1 -> IDLE (glitch rejected, nothing reported); sample 0 -> DATA.
REQ-016 DATA: 8 bits sampled LSB first, each CLKS_PER_BIT cycles after the previous sample; after bit 7 -> PARITY when REQ-027 is enabled, otherwise -> STOP.
REQ-017 STOP: s2 sampled CLKS_PER_BIT after the previous sample; 1 -> byte pushed, -> IDLE; 0 -> o_frame_err pulse, byte discarded, -> WAIT_HIGH.
REQ-018 WAIT_HIGH SHALL stay until s2 reads 1, then go to IDLE; break conditions therefore yield exactly one frame_err.
REQ-019 Pushed byte SHALL be visible with o_vld high in the cycle after the stop sample (with CLKS_PER_BIT=16 and no parity: D+152, i.e. 154 cycles after an i_rx fall registered at a clock edge).
REQ-020 FIFO SHALL be 2^FIFO_AW entries with FIFO_AW+1-bit read/write pointers that wrap naturally; full when the MSBs differ and the low bits are equal.
REQ-021 o_rdt SHALL present the head entry combinationally from the FIFO storage; it SHALL hold stable while o_vld=1 and i_rdy=0.
REQ-022 Push while full with no pop in the same cycle -> byte dropped, o_ovf pulse, FIFO contents unchanged.
REQ-023 Simultaneous push and pop while full SHALL accept both; no o_ovf.
REQ-024 Simultaneous push and pop while empty SHALL NOT pop (o_vld was 0); the byte is stored.

Reset
REQ-025 wb_rst high SHALL asynchronously force s1=s2=1, FSM=IDLE, FIFO pointers=0, o_vld=0, o_frame_err=o_ovf=o_par_err=0; o_rdt is don't-care while o_vld=0.
REQ-026 Reset mid-frame SHALL discard the partial byte and FIFO contents; after release, reception SHALL resume only on a new falling edge.

Configuration
REQ-027 Macro SERVANT_UART_RX_PARITY_EN defined: a PARITY state samples one even-parity bit after bit 7; mismatch -> o_par_err pulse at the stop sample, byte discarded, FSM still checks the stop bit; undefined: no PARITY state, o_par_err tied 0, frame is 8N1.

Verification
REQ-028 CLKS_PER_BIT=16, i_rdy=1, 8N1 frame 0x55 -> o_rdt=0x55, o_vld high for exactly 1 cycle, 154 cycles after the start edge.
REQ-029 i_rdy=0, frames 0x01..0x05 -> first 4 stored, o_ovf pulses once on the 0x05 frame; i_rdy=1 then drains 0x01,0x02,0x03,0x04 in order.
REQ-030 i_rx low for 4 cycles only -> no o_vld, no errors, FSM back in IDLE.
REQ-031 Frame 0xA3 with stop bit 0, line held low 40 bit times -> single o_frame_err pulse, no push; a following good frame 0x3C is received correctly.
REQ-032 wb_rst asserted during bit 3 of a frame -> all outputs 0 immediately; the next full frame 0x7E is received correctly.
REQ-033 With SERVANT_UART_RX_PARITY_EN: 0x07 with parity bit 0 -> o_par_err pulse, no push; 0x07 with parity bit 1 -> 0x07 received.
